// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// opcodes and the ALU operation codes it drives.
package control_unit_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_EXECUTE   = 3'b010,
        S_MEMORY    = 3'b011,
        S_WRITEBACK = 3'b100,
        S_HALT      = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        OP_LD  = 3'b000,
        OP_ST  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    function automatic logic [2:0] alu_op_of(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_alu_op(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and its datapath: IR/flag inputs in,
// state visibility and every datapath strobe out.
interface control_unit_if;
    logic [7:0] instr;
    logic       zf;
    logic [2:0] state;
    logic [2:0] next_state;
    logic       pc_we;
    logic       pc_sel;
    logic       pc_jmp_sel;
    logic [3:0] pc_offset;
    logic [3:0] addr_offset;
    logic       addr_sel;
    logic       mem_sel;
    logic       mem_we;
    logic [2:0] alu_opcode;
    logic       alu_sel_a;
    logic       alu_sel_b;
    logic       alu_we;
    logic       zf_we;
    logic       ir_we;
    logic       a_sel;
    logic       a_we;
    logic       b_sel;
    logic       b_we;
    logic       halt;

    // Datapath side: supplies IR and flag, consumes control.
    modport master (
        output instr, zf,
        input  state, next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
               addr_offset, addr_sel, mem_sel, mem_we, alu_opcode,
               alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we,
               a_sel, a_we, b_sel, b_we, halt
    );

    modport slave (
        input  instr, zf,
        output state, next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset,
               addr_offset, addr_sel, mem_sel, mem_we, alu_opcode,
               alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we,
               a_sel, a_we, b_sel, b_we, halt
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM: a state register plus one combinational decode of
// state, instr and zf into next state and datapath strobes.
//
// state     | meaning
// FETCH     | read IR from mem[PC], PC <= PC+1
// DECODE    | opcode settles, choose HALT or EXECUTE
// EXECUTE   | ALU op, branch, or pass LD/ST on to MEMORY
// MEMORY    | address = B+offset; store or read for load
// WRITEBACK | write ALU result or load data into A/B
// HALT      | parked until reset
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    control_unit_if.slave  bus
);

    state_t  r_state;
    state_t  w_next_state;
    opcode_t w_op;
    logic    w_r;

    assign w_op = opcode_t'(bus.instr[7:5]);
    assign w_r  = bus.instr[4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    assign bus.state      = r_state;
    assign bus.next_state = w_next_state;

    always_comb begin
        w_next_state    = S_FETCH;
        bus.pc_we       = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.pc_jmp_sel  = 1'b0;
        bus.pc_offset   = 4'd0;
        bus.addr_offset = 4'd0;
        bus.addr_sel    = 1'b0;
        bus.mem_sel     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.alu_opcode  = ALU_ADD;
        bus.alu_sel_a   = 1'b0;
        bus.alu_sel_b   = 1'b0;
        bus.alu_we      = 1'b0;
        bus.zf_we       = 1'b0;
        bus.ir_we       = 1'b0;
        bus.a_sel       = 1'b0;
        bus.a_we        = 1'b0;
        bus.b_sel       = 1'b0;
        bus.b_we        = 1'b0;
        bus.halt        = 1'b0;

        // Decode is gated by reset so nothing strobes while the datapath is held.
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    bus.ir_we    = 1'b1;
                    bus.pc_we    = 1'b1;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    w_next_state = (w_op == OP_HLT) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_alu_op(w_op)) begin
                        bus.alu_opcode = alu_op_of(w_op);
                        bus.alu_sel_a  = w_r;
                        bus.alu_sel_b  = bus.instr[3];
                        bus.alu_we     = 1'b1;
                        bus.zf_we      = 1'b1;
                        w_next_state   = S_WRITEBACK;
                    end else if (w_op == OP_LD || w_op == OP_ST) begin
                        w_next_state = S_MEMORY;
                    end else if (w_op == OP_JMP) begin
                        bus.pc_we     = 1'b1;
                        bus.pc_sel    = 1'b1;
                        bus.pc_offset = bus.instr[3:0];
                    end else if (w_op == OP_JZ) begin
                        bus.pc_we     = bus.zf;
                        bus.pc_sel    = 1'b1;
                        bus.pc_offset = bus.instr[3:0];
                    end
                end
                S_MEMORY: begin
                    if (w_op == OP_LD) begin
                        bus.addr_sel    = 1'b1;
                        bus.addr_offset = bus.instr[3:0];
                        w_next_state    = S_WRITEBACK;
                    end else if (w_op == OP_ST) begin
                        bus.addr_sel    = 1'b1;
                        bus.addr_offset = bus.instr[3:0];
                        bus.mem_sel     = w_r;
                        bus.mem_we      = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (w_op == OP_LD || is_alu_op(w_op)) begin
                        bus.a_we  = ~w_r;
                        bus.b_we  = w_r;
                        bus.a_sel = (w_op == OP_LD) & ~w_r;
                        bus.b_sel = (w_op == OP_LD) & w_r;
                    end
                end
                S_HALT: begin
                    bus.halt     = 1'b1;
                    w_next_state = S_HALT;
                end
                default: w_next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class through its
// states and compares every strobe against hand-computed vectors.
module tb_control_unit;
    import control_unit_pkg::*;

    typedef struct packed {
        logic       pc_we;
        logic       pc_sel;
        logic       pc_jmp_sel;
        logic [3:0] pc_offset;
        logic [3:0] addr_offset;
        logic       addr_sel;
        logic       mem_sel;
        logic       mem_we;
        logic [2:0] alu_opcode;
        logic       alu_sel_a;
        logic       alu_sel_b;
        logic       alu_we;
        logic       zf_we;
        logic       ir_we;
        logic       a_sel;
        logic       a_we;
        logic       b_sel;
        logic       b_we;
        logic       halt;
    } ctl_t;

    logic clk;
    logic clk_en;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    ctl_t obs;
    ctl_t e;

    control_unit_if cu_if();

    control_unit dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (cu_if)
    );

    assign obs = {cu_if.pc_we, cu_if.pc_sel, cu_if.pc_jmp_sel, cu_if.pc_offset,
                  cu_if.addr_offset, cu_if.addr_sel, cu_if.mem_sel, cu_if.mem_we,
                  cu_if.alu_opcode, cu_if.alu_sel_a, cu_if.alu_sel_b, cu_if.alu_we,
                  cu_if.zf_we, cu_if.ir_we, cu_if.a_sel, cu_if.a_we, cu_if.b_sel,
                  cu_if.b_we, cu_if.halt};

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic phase(input string tag, input logic [2:0] st, input logic [2:0] nx, input ctl_t ex);
        check_eq({tag, "/state"}, {29'd0, cu_if.state}, {29'd0, st});
        check_eq({tag, "/next"}, {29'd0, cu_if.next_state}, {29'd0, nx});
        check_eq({tag, "/ctl"}, {5'd0, obs}, {5'd0, ex});
    endtask

    function automatic ctl_t fetch_ctl();
        ctl_t c = '0;
        c.ir_we = 1'b1;
        c.pc_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t halt_ctl();
        ctl_t c = '0;
        c.halt = 1'b1;
        return c;
    endfunction

    logic [7:0] halt_vec [8] = '{8'b00011100, 8'b00111100, 8'b01011000, 8'b01111111,
                                 8'b10011111, 8'b10111111, 8'b11011111, 8'b11111111};

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        clk_en       = 1'b0;
        rst_n        = 1'b0;
        cu_if.instr  = 8'b11100000;
        cu_if.zf     = 1'b1;

        // Reset held, clock idle.
        #2;
        phase("rst_low", 3'b000, 3'b000, '0);
        rst_n = 1'b1;
        #1;
        phase("rst_rel", 3'b000, 3'b001, fetch_ctl());

        // HLT: FETCH -> DECODE -> HALT, then parked.
        clk_en = 1'b1;
        @(negedge clk); #1;
        phase("hlt_dec", 3'b001, 3'b101, '0);
        @(negedge clk); #1;
        phase("hlt_enter", 3'b101, 3'b101, halt_ctl());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            phase("hlt_stay", 3'b101, 3'b101, halt_ctl());
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cu_if.zf    = 1'b0;
            cu_if.instr = halt_vec[i];
            #1;
            phase("halt_instr", 3'b101, 3'b101, halt_ctl());
        end
        cu_if.zf = 1'b1;
        #1;
        phase("halt_zf1", 3'b101, 3'b101, halt_ctl());

        // Asynchronous reset out of HALT while clk is high.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        phase("async_rst", 3'b000, 3'b000, '0);
        @(negedge clk); #1;
        phase("rst_hold", 3'b000, 3'b000, '0);

        // JZ 11000101.
        rst_n       = 1'b1;
        cu_if.instr = 8'b11000101;
        cu_if.zf    = 1'b0;
        #1;
        phase("jz_fetch", 3'b000, 3'b001, fetch_ctl());
        @(negedge clk); #1;
        phase("jz_dec", 3'b001, 3'b010, '0);
        @(negedge clk); #1;
        e = '0; e.pc_sel = 1'b1; e.pc_offset = 4'b0101;
        phase("jz_ex_zf0", 3'b010, 3'b000, e);
        cu_if.zf = 1'b1;
        #1;
        e.pc_we = 1'b1;
        phase("jz_ex_zf1", 3'b010, 3'b000, e);

        // LD 00010011 into B.
        @(negedge clk);
        cu_if.instr = 8'b00010011;
        cu_if.zf    = 1'b0;
        #1;
        phase("ld_fetch", 3'b000, 3'b001, fetch_ctl());
        @(negedge clk); #1;
        phase("ld_dec", 3'b001, 3'b010, '0);
        @(negedge clk); #1;
        phase("ld_ex", 3'b010, 3'b011, '0);
        @(negedge clk); #1;
        e = '0; e.addr_sel = 1'b1; e.addr_offset = 4'b0011;
        phase("ld_mem", 3'b011, 3'b100, e);
        @(negedge clk); #1;
        e = '0; e.b_we = 1'b1; e.b_sel = 1'b1;
        phase("ld_wb", 3'b100, 3'b000, e);

        // SUB 01101010: A - imm(010), result to A.
        @(negedge clk);
        cu_if.instr = 8'b01101010;
        #1;
        phase("sub_fetch", 3'b000, 3'b001, fetch_ctl());
        @(negedge clk); #1;
        phase("sub_dec", 3'b001, 3'b010, '0);
        @(negedge clk); #1;
        e = '0; e.alu_opcode = 3'b001; e.alu_sel_b = 1'b1; e.alu_we = 1'b1; e.zf_we = 1'b1;
        phase("sub_ex", 3'b010, 3'b100, e);
        @(negedge clk); #1;
        e = '0; e.a_we = 1'b1;
        phase("sub_wb", 3'b100, 3'b000, e);

        // ST 00111100: store B at B+1100.
        @(negedge clk);
        cu_if.instr = 8'b00111100;
        @(negedge clk); @(negedge clk); #1;
        phase("st_ex", 3'b010, 3'b011, '0);
        @(negedge clk); #1;
        e = '0; e.addr_sel = 1'b1; e.addr_offset = 4'b1100; e.mem_sel = 1'b1; e.mem_we = 1'b1;
        phase("st_mem", 3'b011, 3'b000, e);

        // JMP 10100111.
        @(negedge clk);
        cu_if.instr = 8'b10100111;
        @(negedge clk); @(negedge clk); #1;
        e = '0; e.pc_we = 1'b1; e.pc_sel = 1'b1; e.pc_offset = 4'b0111;
        phase("jmp_ex", 3'b010, 3'b000, e);

        // ADD 01011101: B + B, result to B.
        @(negedge clk);
        cu_if.instr = 8'b01011101;
        @(negedge clk); @(negedge clk); #1;
        e = '0; e.alu_opcode = 3'b000; e.alu_sel_a = 1'b1; e.alu_sel_b = 1'b1;
        e.alu_we = 1'b1; e.zf_we = 1'b1;
        phase("add_ex", 3'b010, 3'b100, e);
        @(negedge clk); #1;
        e = '0; e.b_we = 1'b1;
        phase("add_wb", 3'b100, 3'b000, e);

        // AND 10000100: A & B, result to A.
        @(negedge clk);
        cu_if.instr = 8'b10000100;
        @(negedge clk); @(negedge clk); #1;
        e = '0; e.alu_opcode = 3'b010; e.alu_we = 1'b1; e.zf_we = 1'b1;
        phase("and_ex", 3'b010, 3'b100, e);
        @(negedge clk); #1;
        e = '0; e.a_we = 1'b1;
        phase("and_wb", 3'b100, 3'b000, e);

        // Reset mid-instruction (EXECUTE) abandons it.
        @(negedge clk);
        cu_if.instr = 8'b01011101;
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        phase("mid_rst", 3'b000, 3'b000, '0);
        rst_n = 1'b1;
        #1;
        phase("mid_rel", 3'b000, 3'b001, fetch_ctl());
        @(negedge clk); #1;
        phase("mid_dec", 3'b001, 3'b010, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
